// File: rtl/align_p2s_stream.sv
// align_p2s_stream: wide-word to narrow-beat serializer with valid/ready on
// both sides. Slices go out LSB first. A one-word skid buffer (nxt) lets the
// following word queue up while cur is still being sent, so consecutive words
// leave back to back without a gap between them.
module align_p2s_stream #(
  parameter int IDATA_WIDTH = 256,
  parameter int ODATA_BIT   = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [IDATA_WIDTH-1:0] idata,
  input  logic                   idata_valid,
  output logic                   idata_ready,
  output logic [ODATA_BIT-1:0]   odata,
  output logic                   odata_valid,
  input  logic                   odata_ready,
  output logic                   odata_last,
  output logic                   busy
);

  localparam int REG_NUM = IDATA_WIDTH / ODATA_BIT;
  localparam int CNT_BIT = $clog2(REG_NUM);
  localparam logic [CNT_BIT-1:0] LAST_CNT = CNT_BIT'(REG_NUM - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]                            state;
  logic [REG_NUM-1:0][ODATA_BIT-1:0]     cur;
  logic [CNT_BIT-1:0]                    cnt;
  logic [IDATA_WIDTH-1:0]                nxt;
  logic                                  nxt_valid;

  logic in_fire, out_fire, word_done, bypass;

  // Ready comes from registers and rst only, so odata_ready never reaches
  // idata_ready combinationally.
  assign idata_ready = ~rst & ~nxt_valid;
  assign odata_valid = (state == SEND);
  assign odata       = cur[cnt];
  assign odata_last  = odata_valid & (cnt == LAST_CNT);
  assign busy        = (state == SEND) | nxt_valid;

  assign in_fire   = idata_valid & idata_ready;
  assign out_fire  = odata_valid & odata_ready;
  assign word_done = out_fire & (cnt == LAST_CNT);
  // A word arriving as the last beat leaves, with nothing buffered, loads
  // straight into cur instead of passing through nxt.
  assign bypass    = word_done & ~nxt_valid & in_fire;

  // Serializer state: beat counter, current word, skid buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cur       <= '0;
      nxt       <= '0;
      nxt_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_fire) begin
            cur   <= idata;
            cnt   <= '0;
            state <= SEND;
          end
        end
        SEND: begin
          if (out_fire) begin
            if (cnt != LAST_CNT) begin
              cnt <= cnt + 1'b1;
            end else if (nxt_valid) begin
              cur       <= nxt;
              nxt_valid <= 1'b0;
              cnt       <= '0;
            end else if (in_fire) begin
              cur <= idata;
              cnt <= '0;
            end else begin
              state <= IDLE;
            end
          end
          if (in_fire && !bypass) begin
            nxt       <= idata;
            nxt_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
